// File: rtl/moving_average_mc.sv
// Multi-channel interleaved moving average: per-channel history and running sum,
// run-time power-of-two window, round-half-up signed mean, 2-cycle latency.

module moving_average_ch #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DEPTH = 6,
    parameter int KW         = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 wr_en,
    input  logic signed [DATA_WIDTH-1:0]         x,
    input  logic        [KW-1:0]                 k,
    output logic signed [DATA_WIDTH+LOG2_DEPTH-1:0] acc_new,
    output logic                                 primed
);
    localparam int D  = 1 << LOG2_DEPTH;
    localparam int AW = DATA_WIDTH + LOG2_DEPTH;

    logic signed [DATA_WIDTH-1:0] hist [D];
    logic        [LOG2_DEPTH-1:0] ptr;
    logic        [LOG2_DEPTH:0]   fill;
    logic        [LOG2_DEPTH:0]   win;
    logic signed [AW-1:0]         acc;
    logic signed [DATA_WIDTH-1:0] old;

    // The sample leaving the window sits W slots behind the write pointer; with
    // W == D that is the slot about to be overwritten.
    always_comb begin
        win     = (LOG2_DEPTH+1)'(1) << k;
        old     = (fill >= win) ? hist[ptr - win[LOG2_DEPTH-1:0]] : '0;
        acc_new = acc + {{LOG2_DEPTH{x[DATA_WIDTH-1]}}, x}
                      - {{LOG2_DEPTH{old[DATA_WIDTH-1]}}, old};
        primed  = ({1'b0, fill} + (LOG2_DEPTH+2)'(1)) >= {1'b0, win};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            fill <= '0;
            acc  <= '0;
        end else if (flush) begin
            ptr  <= '0;
            fill <= '0;
            acc  <= '0;
        end else if (wr_en) begin
            acc <= acc_new;
            ptr <= ptr + LOG2_DEPTH'(1);
            if (fill != (LOG2_DEPTH+1)'(D))
                fill <= fill + (LOG2_DEPTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            hist[ptr] <= x;
    end
endmodule

module moving_average_mc #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_CHANNELS    = 4,
    parameter int MAX_LOG2_WINDOW = 6,
    parameter int CH_WIDTH        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int KW             = $clog2(MAX_LOG2_WINDOW + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [KW-1:0]                log2_window,
    input  logic                         in_valid,
    input  logic [CH_WIDTH-1:0]          in_channel,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [CH_WIDTH-1:0]          out_channel,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_primed
);
    localparam int AW     = DATA_WIDTH + MAX_LOG2_WINDOW;
    localparam int STAGES = 2;

    typedef struct packed {
        logic signed [AW-1:0]  acc;
        logic [CH_WIDTH-1:0]   ch;
        logic                  primed;
        logic [KW-1:0]         k;
    } s1_t;

    logic [KW-1:0]                      k_r, k_clamp;
    logic                               flush, accept;
    logic [STAGES:0]                    vld_pipe;
    logic [NUM_CHANNELS-1:0][AW-1:0]    acc_new;
    logic [NUM_CHANNELS-1:0]            primed;
    logic signed [AW-1:0]               sel_acc;
    logic                               sel_primed;
    s1_t                                s1;
    logic [AW:0]                        bias;
    logic signed [AW:0]                 rnd;

    assign k_clamp  = (log2_window > KW'(MAX_LOG2_WINDOW)) ? KW'(MAX_LOG2_WINDOW) : log2_window;
    assign flush    = clear || (k_clamp != k_r);
    assign in_ready = !flush;
    assign accept   = in_valid && !flush &&
                      ({1'b0, in_channel} < (CH_WIDTH+1)'(NUM_CHANNELS));
    assign vld_pipe[0] = accept;
    assign out_valid   = vld_pipe[STAGES];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        moving_average_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .LOG2_DEPTH (MAX_LOG2_WINDOW),
            .KW         (KW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .wr_en   (accept && (in_channel == CH_WIDTH'(c))),
            .x       (in_data),
            .k       (k_r),
            .acc_new (acc_new[c]),
            .primed  (primed[c])
        );
    end

    always_comb begin
        sel_acc    = '0;
        sel_primed = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (in_channel == CH_WIDTH'(c)) begin
                sel_acc    = acc_new[c];
                sel_primed = primed[c];
            end
        end
    end

    // Stage 2 rounds with the window captured at accept time, not the live k_r.
    always_comb begin
        bias = (s1.k == '0) ? '0 : ((AW+1)'(1) << (s1.k - KW'(1)));
        rnd  = $signed({s1.acc[AW-1], s1.acc}) + $signed(bias);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_r                <= '0;
            vld_pipe[STAGES:1] <= '0;
            s1                 <= '0;
            out_channel        <= '0;
            out_data           <= '0;
            out_primed         <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (flush)
                k_r <= k_clamp;
            if (accept)
                s1 <= '{acc: sel_acc, ch: in_channel, primed: sel_primed, k: k_r};
            if (vld_pipe[1]) begin
                out_channel <= s1.ch;
                out_data    <= DATA_WIDTH'(rnd >>> s1.k);
                out_primed  <= s1.primed;
            end
        end
    end
endmodule
